sync_fifo: RTL and testbench

- Single-clock, synchronous first-in-first-out buffer.
- A producer pushes data words with WREQ/WD; a consumer pops them with RREQ/RD.
- Full (f) and empty (e) status flags provide flow control.
- Sits between two blocks in the same clock domain as an elastic rate-matching buffer.

---
 rtl/sync_fifo_pkg.sv | 9 +
 rtl/sync_fifo_if.sv | 30 +++
 rtl/sync_fifo_mem.sv | 36 +++
 rtl/sync_fifo.sv | 83 ++++++++
 tb/tb_sync_fifo.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared defaults and types for the single-clock FIFO slice.
package sync_fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH      = 16;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake and status bundle for sync_fifo.
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH
);
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);

    logic                  WREQ;
    logic [DATA_WIDTH-1:0] WD;
    logic                  RREQ;
    logic [DATA_WIDTH-1:0] RD;
    logic                  f;
    logic                  e;
    logic [ADDR_WIDTH:0]   count;
    logic                  ovf;
    logic                  udf;

    modport master (
        output WREQ, WD, RREQ,
        input  RD, f, e, count, ovf, udf
    );

    modport slave (
        input  WREQ, WD, RREQ,
        output RD, f, e, count, ovf, udf
    );

endinterface

// File: rtl/sync_fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read.
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately left unreset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count, flag decode and ovf/udf pulses.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    sync_fifo_if.slave  bus
);

    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;
    logic                  wr_en;
    logic                  rd_en;
    logic                  ovf;
    logic                  udf;

    always_comb begin
        full  = (count == CNT_FULL);
        empty = (count == '0);
        wr_en = bus.WREQ & ~full;
        rd_en = bus.RREQ & ~empty;
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            ovf <= bus.WREQ & full;
            udf <= bus.RREQ & empty;
            if (wr_en) begin
                wptr <= wptr + PTR_ONE;
            end
            if (rd_en) begin
                rptr <= rptr + PTR_ONE;
            end
            unique case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wptr),
        .wr_data (bus.WD),
        .rd_en   (rd_en),
        .rd_addr (rptr),
        .rd_data (bus.RD)
    );

    always_comb begin
        bus.f     = full;
        bus.e     = empty;
        bus.count = count;
        bus.ovf   = ovf;
        bus.udf   = udf;
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo with hand-computed expectations.
module tb_sync_fifo;
    import sync_fifo_pkg::*;

    logic clk;
    logic rst;
    int unsigned n_checks;
    int unsigned n_pass;

    sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();

    sync_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic wreq, input logic rreq, input data_t wd);
        bus.WREQ = wreq;
        bus.RREQ = rreq;
        bus.WD   = wd;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        drive(1'b1, 1'b0, 8'hAA);
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        check("rst_e", 32'(bus.e), 32'd1);
        check("rst_f", 32'(bus.f), 32'd0);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_rd", 32'(bus.RD), 32'h00);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_udf", 32'(bus.udf), 32'd0);
        step();
        check("rst_nothing_stored", 32'(bus.count), 32'd0);

        // Fill with 00..0F
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b0, 8'(i));
            step();
            check("fill_count", 32'(bus.count), 32'(i + 1));
            check("fill_ovf", 32'(bus.ovf), 32'd0);
        end
        check("full_f", 32'(bus.f), 32'd1);
        check("full_e", 32'(bus.e), 32'd0);

        drive(1'b1, 1'b0, 8'hFF);
        step();
        check("ovf_pulse", 32'(bus.ovf), 32'd1);
        check("ovf_count", 32'(bus.count), 32'd16);
        drive(1'b0, 1'b0, 8'h00);
        step();
        check("ovf_clear", 32'(bus.ovf), 32'd0);

        // Drain: RD valid right after each accepting edge
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            step();
            check("drain_rd", 32'(bus.RD), 32'(i));
            check("drain_count", 32'(bus.count), 32'(15 - i));
        end
        check("drain_e", 32'(bus.e), 32'd1);
        check("drain_f", 32'(bus.f), 32'd0);

        step();
        check("udf_pulse", 32'(bus.udf), 32'd1);
        check("udf_rd_hold", 32'(bus.RD), 32'h0F);
        check("udf_count", 32'(bus.count), 32'd0);
        check("udf_e", 32'(bus.e), 32'd1);
        drive(1'b0, 1'b0, 8'h00);
        step();
        check("udf_clear", 32'(bus.udf), 32'd0);

        // Simultaneous while empty: write only
        drive(1'b1, 1'b1, 8'h50);
        step();
        check("sim_empty_count", 32'(bus.count), 32'd1);
        check("sim_empty_udf", 32'(bus.udf), 32'd1);
        check("sim_empty_rd", 32'(bus.RD), 32'h0F);
        for (int i = 1; i < 5; i++) begin
            drive(1'b1, 1'b0, 8'(8'h50 + i));
            step();
        end
        check("sim_pre_count", 32'(bus.count), 32'd5);

        // Steady state at count 5, crossing pointer wrap
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 1'b1, 8'(8'h55 + k));
            step();
            check("sim_rd", 32'(bus.RD), 32'(8'h50 + k));
            check("sim_count", 32'(bus.count), 32'd5);
        end

        // Top up to full with 69..73
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 1'b0, 8'(8'h69 + i));
            step();
        end
        check("refill_count", 32'(bus.count), 32'd16);
        drive(1'b1, 1'b1, 8'hEE);
        step();
        check("sim_full_count", 32'(bus.count), 32'd15);
        check("sim_full_ovf", 32'(bus.ovf), 32'd1);
        check("sim_full_rd", 32'(bus.RD), 32'h64);

        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            step();
            check("pre_rst_rd", 32'(bus.RD), 32'(8'h65 + i));
        end
        check("pre_rst_count", 32'(bus.count), 32'd7);

        // Mid-operation reset with a read pending is overridden
        rst = 1'b1;
        drive(1'b1, 1'b1, 8'h99);
        step();
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        check("mid_rst_count", 32'(bus.count), 32'd0);
        check("mid_rst_e", 32'(bus.e), 32'd1);
        check("mid_rst_rd", 32'(bus.RD), 32'h00);
        drive(1'b1, 1'b0, 8'h3C);
        step();
        check("post_rst_count", 32'(bus.count), 32'd1);
        drive(1'b0, 1'b1, 8'h00);
        step();
        check("post_rst_rd", 32'(bus.RD), 32'h3C);
        check("post_rst_e", 32'(bus.e), 32'd1);
        drive(1'b0, 1'b0, 8'h00);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
